// File: rtl/icu_irq_sequencer.sv
// CPU-side ICU interrupt handshake sequencer: ack, vector latch, trap request, EOI on return.
// Optional SPURIOUS_CNT_EN adds a saturating counter of spurious (dropped-request) acknowledges.
module icu_irq_sequencer #(
  parameter logic [31:0] VEC_BASE  = 32'h0000_0100,
  parameter int unsigned VEC_SHIFT = 2,
  parameter logic [1:0]  EOI_ADDR  = 2'b11
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_intr,
  input  logic [7:0]  i_vector,
  output logic        o_inta,
  output logic        o_icu_cs,
  output logic        o_icu_we,
  output logic [1:0]  o_icu_addr,
  output logic [7:0]  o_icu_data,
  input  logic        i_ie,
  input  logic        i_insn_boundary,
  output logic        o_int_req,
  output logic [31:0] o_handler_pc,
  input  logic        i_int_ack,
  input  logic        i_iret,
`ifdef SPURIOUS_CNT_EN
  output logic [7:0]  o_spurious_cnt,
`endif
  output logic        o_busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACK,
    S_LATCH,
    S_REQ,
    S_SERVICE,
    S_EOI
  } state_t;

  state_t      r_state;
  logic        r_inta;
  logic        r_icu_cs;
  logic        r_icu_we;
  logic [1:0]  r_icu_addr;
  logic [7:0]  r_icu_data;
  logic        r_int_req;
  logic [31:0] r_handler_pc;
  logic        r_busy;
  logic [2:0]  r_vec_sel;
  logic [31:0] w_handler_pc;
`ifdef SPURIOUS_CNT_EN
  logic [7:0]  r_spurious_cnt;
`endif

  // Only the low three vector bits are needed after LATCH: they select the EOI bit.
  assign w_handler_pc = VEC_BASE + ({24'b0, i_vector} << VEC_SHIFT);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state        <= S_IDLE;
      r_inta         <= 1'b0;
      r_icu_cs       <= 1'b0;
      r_icu_we       <= 1'b0;
      r_icu_addr     <= 2'b00;
      r_icu_data     <= 8'h00;
      r_int_req      <= 1'b0;
      r_handler_pc   <= 32'h0;
      r_busy         <= 1'b0;
      r_vec_sel      <= 3'd0;
`ifdef SPURIOUS_CNT_EN
      r_spurious_cnt <= 8'h00;
`endif
    end else begin
      r_inta     <= 1'b0;
      r_icu_cs   <= 1'b0;
      r_icu_we   <= 1'b0;
      r_icu_addr <= 2'b00;
      r_icu_data <= 8'h00;
      case (r_state)
        S_IDLE: begin
          if (i_intr && i_ie && i_insn_boundary) begin
            r_state <= S_ACK;
            r_inta  <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        S_ACK: begin
          r_state <= S_LATCH;
        end
        S_LATCH: begin
          if (!i_intr) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
`ifdef SPURIOUS_CNT_EN
            if (r_spurious_cnt != 8'hFF) r_spurious_cnt <= r_spurious_cnt + 8'h01;
`endif
          end else begin
            r_state      <= S_REQ;
            r_vec_sel    <= i_vector[2:0];
            r_handler_pc <= w_handler_pc;
            r_int_req    <= 1'b1;
          end
        end
        S_REQ: begin
          if (i_int_ack) begin
            r_state   <= S_SERVICE;
            r_int_req <= 1'b0;
          end
        end
        S_SERVICE: begin
          if (i_iret) begin
            r_state    <= S_EOI;
            r_icu_cs   <= 1'b1;
            r_icu_we   <= 1'b1;
            r_icu_addr <= EOI_ADDR;
            r_icu_data <= 8'h01 << r_vec_sel;
          end
        end
        S_EOI: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_inta       = r_inta;
  assign o_icu_cs     = r_icu_cs;
  assign o_icu_we     = r_icu_we;
  assign o_icu_addr   = r_icu_addr;
  assign o_icu_data   = r_icu_data;
  assign o_int_req    = r_int_req;
  assign o_handler_pc = r_handler_pc;
  assign o_busy       = r_busy;
`ifdef SPURIOUS_CNT_EN
  assign o_spurious_cnt = r_spurious_cnt;
`endif

endmodule
